// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver slice.
//   rx_state_e : receiver FSM states (3-bit encoding)
//   PAR_EVEN / PAR_ODD : values of the Parity_type input
//   maj3       : 2-of-3 majority used by the bit sampler
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Edge counter and mid-bit majority sampler for the UART receiver.
// Ports:
//   CLK            : oversampling clock
//   Reset          : asynchronous, active-low reset
//   run_i          : 1 while the receiver is inside a frame (counter runs)
//   rx_i           : serial line as seen by the receiver
//   bit_o          : majority of the three mid-bit samples
//   bit_done_o     : last edge-count of the current bit period
//   sample_valid_o : bit_o has just become valid for the current bit
// The counter is held at 0 while run_i is low, so the cycle after the start
// edge is detected is edge count 0 of the start bit.
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic CLK,
    input  logic Reset,
    input  logic run_i,
    input  logic rx_i,
    output logic bit_o,
    output logic bit_done_o,
    output logic sample_valid_o
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);

    // The capture at the end of cycle c is the line value seen when the
    // counter moves to c+1, i.e. the samples belong to edge counts M-1..M+1.
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 2);
    localparam logic [CW-1:0] CNT_S1   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S2   = CW'(M);
    localparam logic [CW-1:0] CNT_VLD  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    smp_q, smp_d;

    always_comb begin
        cnt_d = cnt_q;
        smp_d = smp_q;
        if (!run_i) begin
            cnt_d = '0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == CNT_S0) smp_d[0] = rx_i;
            if (cnt_q == CNT_S1) smp_d[1] = rx_i;
            if (cnt_q == CNT_S2) smp_d[2] = rx_i;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
            smp_q <= 3'b111;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

    assign bit_o          = maj3(smp_q);
    assign bit_done_o     = run_i && (cnt_q == CNT_LAST);
    assign sample_valid_o = run_i && (cnt_q == CNT_VLD);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start-bit detection, LSB-first deserialisation,
// optional even/odd parity check and stop-bit check.
// Ports:
//   CLK          : receiver clock, OVERSAMPLE x bit rate
//   Reset        : asynchronous, active-low reset
//   Rx_in        : serial line, idle high
//   Parity_EN    : 1 = a parity bit follows the data bits
//   Parity_type  : 0 = even, 1 = odd parity
//   Data_out     : last correctly received word
//   Data_valid   : one-cycle pulse, Data_out updated
//   Parity_error : one-cycle pulse, parity mismatch
//   Stop_error   : one-cycle pulse, stop bit sampled 0
// Build option: define RX_SYNC_EN to pass Rx_in through a 2-flop synchronizer
// (reset value 1); this adds 2 cycles to every latency. Without it Rx_in must
// be synchronous to CLK.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Rx_in,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    output logic [WIDTH-1:0] Data_out,
    output logic             Data_valid,
    output logic             Parity_error,
    output logic             Stop_error
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    logic rx_s;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], Rx_in};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = Rx_in;
`endif

    rx_state_e        state_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             par_en_q;
    logic             par_type_q;
    logic             par_err_q;

    logic smp_bit;
    logic bit_done;
    logic sample_valid;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .CLK           (CLK),
        .Reset         (Reset),
        .run_i         (state_q != IDLE),
        .rx_i          (rx_s),
        .bit_o         (smp_bit),
        .bit_done_o    (bit_done),
        .sample_valid_o(sample_valid)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= PAR_EVEN;
            par_err_q    <= 1'b0;
            Data_out     <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
        end else begin
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        // Frame configuration is frozen for the whole frame.
                        state_q    <= START;
                        par_en_q   <= Parity_EN;
                        par_type_q <= Parity_type;
                        par_err_q  <= 1'b0;
                        bit_cnt_q  <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        // A high mid-bit sample means the low level was a glitch.
                        state_q   <= smp_bit ? IDLE : DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_q[bit_cnt_q] <= smp_bit;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        par_err_q <= smp_bit != ((^shift_q) ^ (par_type_q == PAR_ODD));
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid-bit so a following start edge is not missed.
                    if (sample_valid) begin
                        Stop_error   <= ~smp_bit;
                        Parity_error <= par_err_q;
                        if (smp_bit && !par_err_q) begin
                            Data_out   <= shift_q;
                            Data_valid <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int W  = 8;
    localparam int OS = 8;
    localparam int M  = OS / 2;
`ifdef RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic         CLK = 1'b0;
    logic         Reset;
    logic         Rx_in;
    logic         Parity_EN;
    logic         Parity_type;
    logic [W-1:0] Data_out;
    logic         Data_valid;
    logic         Parity_error;
    logic         Stop_error;

    always #5 CLK = ~CLK;

    uart_rx #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Rx_in       (Rx_in),
        .Parity_EN   (Parity_EN),
        .Parity_type (Parity_type),
        .Data_out    (Data_out),
        .Data_valid  (Data_valid),
        .Parity_error(Parity_error),
        .Stop_error  (Stop_error)
    );

    typedef struct packed {
        int           cyc;
        logic [W-1:0] data;
        logic         v;
        logic         pe;
        logic         se;
    } ev_t;

    ev_t          exp_q[$];
    ev_t          got_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] last_good = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every cycle with any output pulse becomes one observed event.
    always @(negedge CLK) begin
        if (Reset === 1'b1 && (Data_valid || Parity_error || Stop_error))
            got_q.push_back({cyc, Data_out, Data_valid, Parity_error, Stop_error});
    end

    function automatic int latency(input logic pen);
        return (1 + W + int'(pen)) * OS + M + 3 + SYNC_LAT;
    endfunction

    // Drives one frame starting #1 after a rising edge and queues the outcome
    // predicted from the framing rules. pbad flips the parity bit, sbit is the
    // stop-bit level, scramble changes the parity inputs after the start bit.
    task automatic send(input logic [W-1:0] d, input logic pen, input logic ptype,
                        input logic pbad, input logic sbit, input int gap,
                        input logic scramble);
        logic [W+2:0] bits;
        int           nb;
        int           t_fall;
        logic         pb;
        logic         perr;
        ev_t          e;
        pb = (^d) ^ ptype ^ pbad;
        bits = '0;
        for (int i = 0; i < W; i++) bits[1+i] = d[i];
        if (pen) bits[W+1] = pb;
        bits[W+1+int'(pen)] = sbit;
        nb = W + 2 + int'(pen);
        Parity_EN   = pen;
        Parity_type = ptype;
        t_fall = cyc;
        for (int i = 0; i < nb; i++) begin
            Rx_in = bits[i];
            repeat (OS) @(posedge CLK);
            #1;
            if (i == 0 && scramble) begin
                Parity_EN   = 1'($urandom);
                Parity_type = 1'($urandom);
            end
        end
        Rx_in = 1'b1;
        perr = pen && ((($countones(d) + int'(pb)) % 2) != int'(ptype));
        e.cyc = t_fall + latency(pen);
        e.v   = sbit && !perr;
        e.pe  = perr;
        e.se  = !sbit;
        if (e.v) last_good = d;
        e.data = last_good;
        exp_q.push_back(e);
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
    endtask

    task automatic settle();
        repeat (2 * OS) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Rx_in = 1'b1; Parity_EN = 1'b0; Parity_type = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (Data_out !== '0) begin n_fail++; $display("FAIL reset Data_out: got %h, expected 00", Data_out); end
        n_checks++;
        if (Data_valid !== 1'b0) begin n_fail++; $display("FAIL reset Data_valid: got %b, expected 0", Data_valid); end
        n_checks++;
        if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL reset Parity_error: got %b, expected 0", Parity_error); end
        n_checks++;
        if (Stop_error !== 1'b0) begin n_fail++; $display("FAIL reset Stop_error: got %b, expected 0", Stop_error); end
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        settle();
    endtask

    task automatic test_no_parity();
        exp_q.delete(); got_q.delete();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, OS, 1'b0);
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL no_parity count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL no_parity ev%0d: got cyc=%0d data=%h v=%b pe=%b se=%b, expected cyc=%0d data=%h v=%b pe=%b se=%b", i,
                         got_q[i].cyc, got_q[i].data, got_q[i].v, got_q[i].pe, got_q[i].se, exp_q[i].cyc, exp_q[i].data, exp_q[i].v, exp_q[i].pe, exp_q[i].se);
            end
        end
    endtask

    task automatic test_parity_even();
        exp_q.delete(); got_q.delete();
        send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, OS, 1'b0);
        send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, OS, 1'b0);
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL parity_even count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL parity_even ev%0d: got cyc=%0d data=%h v=%b pe=%b se=%b, expected cyc=%0d data=%h v=%b pe=%b se=%b", i,
                         got_q[i].cyc, got_q[i].data, got_q[i].v, got_q[i].pe, got_q[i].se, exp_q[i].cyc, exp_q[i].data, exp_q[i].v, exp_q[i].pe, exp_q[i].se);
            end
        end
    endtask

    task automatic test_parity_odd_stop();
        exp_q.delete(); got_q.delete();
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, OS, 1'b0);
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 3 * OS, 1'b0);
        send(8'h96, 1'b1, 1'b1, 1'b1, 1'b0, 3 * OS, 1'b0);
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL parity_odd_stop count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL parity_odd_stop ev%0d: got cyc=%0d data=%h v=%b pe=%b se=%b, expected cyc=%0d data=%h v=%b pe=%b se=%b", i,
                         got_q[i].cyc, got_q[i].data, got_q[i].v, got_q[i].pe, got_q[i].se, exp_q[i].cyc, exp_q[i].data, exp_q[i].v, exp_q[i].pe, exp_q[i].se);
            end
        end
    endtask

    task automatic test_glitch();
        exp_q.delete(); got_q.delete();
        Parity_EN = 1'b0; Parity_type = 1'b0;
        Rx_in = 1'b0;
        repeat (M - 2) @(posedge CLK);
        #1;
        Rx_in = 1'b1;
        repeat (3 * OS) @(posedge CLK);
        #1;
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch pulses: got %0d, expected 0", got_q.size()); end
        n_checks++;
        if (Data_out !== last_good) begin n_fail++; $display("FAIL glitch Data_out: got %h, expected %h", Data_out, last_good); end
        send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, OS, 1'b0);
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_next count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL glitch_next ev%0d: got cyc=%0d data=%h v=%b pe=%b se=%b, expected cyc=%0d data=%h v=%b pe=%b se=%b", i,
                         got_q[i].cyc, got_q[i].data, got_q[i].v, got_q[i].pe, got_q[i].se, exp_q[i].cyc, exp_q[i].data, exp_q[i].v, exp_q[i].pe, exp_q[i].se);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); got_q.delete();
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL back_to_back count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back ev%0d: got cyc=%0d data=%h v=%b pe=%b se=%b, expected cyc=%0d data=%h v=%b pe=%b se=%b", i,
                         got_q[i].cyc, got_q[i].data, got_q[i].v, got_q[i].pe, got_q[i].se, exp_q[i].cyc, exp_q[i].data, exp_q[i].v, exp_q[i].pe, exp_q[i].se);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] d;
        exp_q.delete(); got_q.delete();
        d = 8'h77;
        Parity_EN = 1'b0; Parity_type = 1'b0;
        Rx_in = 1'b0;
        repeat (OS) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            Rx_in = d[i];
            repeat (OS) @(posedge CLK);
            #1;
        end
        Rx_in = d[3];
        repeat (M) @(posedge CLK);
        #3;
        Reset = 1'b0;
        #1;
        n_checks++;
        if (Data_out !== '0) begin n_fail++; $display("FAIL midframe_reset Data_out: got %h, expected 00", Data_out); end
        Rx_in = 1'b1;
        last_good = '0;
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        settle();
        send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, OS, 1'b0);
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midframe_reset count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midframe_reset ev%0d: got cyc=%0d data=%h v=%b pe=%b se=%b, expected cyc=%0d data=%h v=%b pe=%b se=%b", i,
                         got_q[i].cyc, got_q[i].data, got_q[i].v, got_q[i].pe, got_q[i].se, exp_q[i].cyc, exp_q[i].data, exp_q[i].v, exp_q[i].pe, exp_q[i].se);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic         pen, ptype, pbad, sbit;
        int           gap;
        exp_q.delete(); got_q.delete();
        for (int n = 0; n < 16; n++) begin
            d     = W'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            pbad  = ($urandom_range(0, 3) == 0);
            sbit  = ($urandom_range(0, 3) != 0);
            gap   = sbit ? $urandom_range(0, 5) : 2 * OS + $urandom_range(0, 5);
            send(d, pen, ptype, pbad, sbit, gap, 1'b1);
        end
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random ev%0d: got cyc=%0d data=%h v=%b pe=%b se=%b, expected cyc=%0d data=%h v=%b pe=%b se=%b", i,
                         got_q[i].cyc, got_q[i].data, got_q[i].v, got_q[i].pe, got_q[i].se, exp_q[i].cyc, exp_q[i].data, exp_q[i].v, exp_q[i].pe, exp_q[i].se);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the test sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Rx_in = 1'b1; Parity_EN = 1'b0; Parity_type = 1'b0;
        test_reset();
        test_no_parity();
        test_parity_even();
        test_parity_odd_stop();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the UART transmitter and consumes its Tx_out line.
- Oversamples the line at OVERSAMPLE× the bit rate and detects the start bit.
- Majority-votes each bit at mid-period, deserializes LSB-first, and checks optional parity and the stop bit.
- Presents a parallel word with a one-cycle valid pulse.

Parameters:
- WIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, CLK cycles per serial bit; must be an even number ≥ 4.

Ports:
- CLK  input  1  receiver clock, OVERSAMPLE× the bit rate.
- Reset  input  1  asynchronous, active-low reset.
- Rx_in  input  1  serial line; idle high.
- Parity_EN  input  1  1 = a parity bit follows the data bits.
- Parity_type  input  1  0 = even parity, 1 = odd parity (parity bit = ~^data).
- Data_out  output  WIDTH  last correctly received word.
- Data_valid  output  1  one-cycle pulse: Data_out updated.
- Parity_error  output  1  one-cycle pulse: parity mismatch.
- Stop_error  output  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (asynchronous, active-low) clears all state.
  - State returns to IDLE; edge counter, bit counter and shift register clear.
  - Data_out resets to 0; Data_valid, Parity_error and Stop_error reset to 0.
  - Reset mid-frame abandons the frame; no flags are raised.
- Edge counter: 0..OVERSAMPLE-1, increments every CLK outside IDLE and wraps to 0 at the end of each bit period.
- Bit sample: majority of Rx_in at edge counts M-1, M and M+1, where M = OVERSAMPLE/2. The result is valid at edge count M+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Rx_in = 0 → START, edge counter = 0. Otherwise stay.
  - START: at the end of the bit period, a sampled value of 0 → DATA. A sampled value of 1 (glitch) → IDLE with no flags raised.
  - DATA: shift the sample into bit position bit_cnt (LSB first). After WIDTH bits: Parity_EN = 1 → PARITY, else → STOP.
  - PARITY: compare the sample with the expected parity (^data XOR Parity_type). Record any mismatch. Then → STOP.
  - STOP: sample at mid-bit, then go to IDLE in the same cycle the result is known. Do not wait for the full bit period, so back-to-back frames are accepted.
- Stop sample results (all pulses are asserted the cycle after the stop sample is valid):
  - Stop sample = 0 → Stop_error pulses for 1 cycle.
  - Parity mismatch recorded → Parity_error pulses for 1 cycle.
  - Stop = 1 and no parity error → Data_out loads the word and Data_valid pulses for 1 cycle.
  - On any error, Data_out holds its old value and Data_valid stays 0.
  - Parity_error and Stop_error may pulse in the same cycle.
- Parity_EN and Parity_type are captured when leaving IDLE; changes mid-frame have no effect.
- Latency: Data_valid asserts (1 + WIDTH + P) × OVERSAMPLE + M + 3 cycles after the falling edge of the start bit, where P = Parity_EN.
- Rx_in held low after a stop error: treated as the start of a new frame.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined: Rx_in passes through a 2-flop synchronizer, reset value 1, before all logic. All latencies increase by 2 cycles.
- Undefined: Rx_in is used directly; the line must be driven synchronously to CLK.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enumeration (IDLE, START, DATA, PARITY, STOP, 3-bit encoding);
  - the parity-type constants PAR_EVEN = 0 and PAR_ODD = 1.
- Sub-module uart_rx_sampler contains the edge counter, the 3-sample majority vote and the bit_done / sample_valid strobes. The FSM and deserializer stay in uart_rx.

Test Plan:
- No parity, frame 0xA5 sent LSB first, stop = 1 → Data_out = 0xA5, Data_valid pulses once at the specified latency, no error flags.
- Parity_EN = 1, Parity_type = 0, data 0x3C with parity bit 0 → valid, Data_out = 0x3C. The same frame with parity bit 1 → Parity_error pulse, Data_out unchanged.
- Parity_type = 1, data 0x01 with parity bit 0 → valid (odd parity). Stop bit forced to 0 → Stop_error pulse, Data_valid stays 0.
- Rx_in low for OVERSAMPLE/2 − 2 cycles, then high → FSM returns to IDLE, no flags, no output change.
- Three back-to-back frames 0x00, 0xFF, 0x5A with no idle gap → three Data_valid pulses, words in order.
- Reset asserted mid-DATA of frame 0x77, then released and frame 0x12 sent → no output for 0x77, Data_out = 0x12.
